// File: rtl/core_fetch_queue.sv
// core_fetch_queue: sequential instruction fetch front end.
// It issues fetch addresses over a valid/ready channel with a bounded number
// of requests in flight, and holds in-order responses in a small queue that
// decode drains. A redirect retargets fetch and discards stale responses.
module core_fetch_queue #(
  parameter int                 ADDR_W          = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC        = 64'h100,
  parameter int                 INST_W          = 32,
  parameter int                 DEPTH           = 4,
  parameter int                 MAX_OUTSTANDING = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       req_valid,
  output logic [ADDR_W-1:0]          req_addr,
  input  logic                       req_ready,
  input  logic                       resp_valid,
  input  logic [INST_W-1:0]          resp_inst,
  output logic                       out_valid,
  output logic [INST_W-1:0]          out_inst,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc4,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + IW + 1;
  localparam logic [IW-1:0]     MAX_OS  = IW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0]     DEPTH_S = SW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [IW-1:0]     inflight;
  logic [IW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [INST_W-1:0] q_inst [DEPTH];

  logic          fire;
  logic          keep;
  logic          pop;
  logic [SW-1:0] reserved;
  logic [IW-1:0] inflight_nxt;
  logic [IW-1:0] drop_nxt;
  logic [CW-1:0] count_nxt;

  // Slots already promised: queued entries plus kept (non-stale) requests in
  // flight. drop_cnt never exceeds inflight, so this cannot go negative.
  assign reserved  = SW'(count) + SW'(inflight) - SW'(drop_cnt);
  assign req_valid = (inflight < MAX_OS) && (reserved < DEPTH_S);
  assign req_addr  = fetch_pc;

  assign fire = req_valid && req_ready;
  assign keep = resp_valid && (drop_cnt == '0) && !redirect;
  assign pop  = out_valid && out_ready && !redirect;

  // Next-state arithmetic for the in-flight, stale-response and queue counters.
  always_comb begin
    inflight_nxt = inflight + IW'(fire) - IW'(resp_valid);
    drop_nxt     = drop_cnt;
    count_nxt    = count + CW'(keep) - CW'(pop);
    if (redirect) begin
      drop_nxt  = inflight_nxt;
      count_nxt = '0;
    end else if (resp_valid && (drop_cnt != '0)) begin
      drop_nxt = drop_cnt - 1'b1;
    end
  end

  // Control state: PCs, counters and queue pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= inflight_nxt;
      drop_cnt <= drop_nxt;
      count    <= count_nxt;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (fire) fetch_pc <= fetch_pc + STEP;
        if (keep) begin
          resp_pc <= resp_pc + STEP;
          tail    <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
      end
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clock) begin
    if (keep) begin
      q_pc[tail]   <= resp_pc;
      q_inst[tail] <= resp_inst;
    end
  end

  // Head view is forced to zero when empty so idle outputs are deterministic.
  always_comb begin
    out_valid = (count != '0);
    out_pc    = '0;
    out_pc4   = '0;
    out_inst  = '0;
    if (out_valid) begin
      out_pc   = q_pc[head];
      out_pc4  = q_pc[head] + STEP;
      out_inst = q_inst[head];
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_core_fetch_queue.sv
// Directed bench for core_fetch_queue with a behavioural fixed-latency memory.
module tb_core_fetch_queue;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [63:0] out_pc4;
  logic        out_ready;
  logic [2:0]  occupancy;

  core_fetch_queue dut (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_inst   (resp_inst),
    .out_valid   (out_valid),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_pc4     (out_pc4),
    .out_ready   (out_ready),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  int          cyc;
  int          lat;
  logic        rdy, ordy, redir;
  logic [63:0] redir_pc;
  logic [63:0] exp_pc;
  logic [63:0] first_pc;
  int          pops;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response and controls at negedge, record any
  // fire into the memory, check any pop against the expected PC stream,
  // then sample just after the rising edge.
  task automatic step();
    @(negedge clock);
    resp_valid = 1'b0;
    resp_inst  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_inst  = inst_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    req_ready   = rdy;
    out_ready   = ordy;
    redirect    = redir;
    redirect_pc = redir_pc;
    if (req_valid && req_ready) mem_q.push_back('{addr: req_addr, due: cyc + lat});
    if (out_valid && out_ready && !redirect) begin
      pops++;
      if (pops == 1) first_pc = out_pc;
      check_val("pop_pc", out_pc, exp_pc);
      check_val("pop_inst", {32'b0, out_inst}, {32'b0, inst_of(exp_pc)});
      check_val("pop_pc4", out_pc4, exp_pc + 64'd4);
      exp_pc = exp_pc + 64'd4;
    end
    if (redirect) exp_pc = redirect_pc;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset      = 1'b1;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_inst  = '0;
    redirect   = 1'b0;
    out_ready  = 1'b0;
    rdy = 0; ordy = 0; redir = 0; redir_pc = '0;
    mem_q.delete();
    exp_pc   = 64'h100;
    pops     = 0;
    first_pc = '1;
    #1;
    check_val("rst_occ", {61'b0, occupancy}, 64'd0);
    check_val("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check_val("rst_out_pc", out_pc, 64'd0);
    check_val("rst_out_pc4", out_pc4, 64'd0);
    check_val("rst_out_inst", {32'b0, out_inst}, 64'd0);
    check_val("rst_req_valid", {63'b0, req_valid}, 64'd1);
    check_val("rst_req_addr", req_addr, 64'h100);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; lat = 1;
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_inst = '0; out_ready = 1'b0;

    // Streaming with 1-cycle memory.
    do_reset();
    lat = 1; rdy = 1; ordy = 1;
    step();
    check_val("s_req_addr1", req_addr, 64'h104);
    check_val("s_valid_early", {63'b0, out_valid}, 64'd0);
    step();
    check_val("s_first_valid", {63'b0, out_valid}, 64'd1);
    check_val("s_first_pc", out_pc, 64'h100);
    check_val("s_first_pc4", out_pc4, 64'h104);
    check_val("s_first_inst", {32'b0, out_inst}, {32'b0, inst_of(64'h100)});
    for (int i = 0; i < 8; i++) begin
      step();
      check_val("s_thru_valid", {63'b0, out_valid}, 64'd1);
      check_val("s_req_addr", req_addr, 64'h10C + 64'(4 * i));
    end

    // Back-pressure: queue fills, fetch stalls, then drains in order.
    do_reset();
    lat = 1; rdy = 1; ordy = 0;
    for (int i = 0; i < 10; i++) step();
    check_val("bp_occ", {61'b0, occupancy}, 64'd4);
    check_val("bp_req_valid", {63'b0, req_valid}, 64'd0);
    check_val("bp_inflight", 64'(mem_q.size()), 64'd0);
    check_val("bp_req_addr", req_addr, 64'h110);
    check_val("bp_head_pc", out_pc, 64'h100);
    ordy = 1;
    for (int i = 0; i < 8; i++) step();
    check_val("bp_drained", 64'(pops >= 4), 64'd1);

    // Redirect with two requests outstanding on 3-cycle memory.
    do_reset();
    lat = 3; rdy = 1; ordy = 1;
    step();
    step();
    check_val("rd_outstanding", 64'(mem_q.size()), 64'd2);
    check_val("rd_credit_full", {63'b0, req_valid}, 64'd0);
    redir = 1; redir_pc = 64'h2000;
    step();
    redir = 0;
    check_val("rd_occ", {61'b0, occupancy}, 64'd0);
    check_val("rd_out_valid", {63'b0, out_valid}, 64'd0);
    check_val("rd_req_addr", req_addr, 64'h2000);
    for (int i = 0; i < 12; i++) step();
    check_val("rd_any_pop", 64'(pops > 0), 64'd1);
    check_val("rd_first_pc", first_pc, 64'h2000);

    // Redirect coinciding with a fire and a response.
    do_reset();
    lat = 1; rdy = 1; ordy = 1;
    step();
    redir = 1; redir_pc = 64'h3000;
    step();
    redir = 0;
    check_val("sim_occ0", {61'b0, occupancy}, 64'd0);
    check_val("sim_req_addr", req_addr, 64'h3000);
    step();
    check_val("sim_dropped", {61'b0, occupancy}, 64'd0);
    check_val("sim_dropped_v", {63'b0, out_valid}, 64'd0);
    step();
    check_val("sim_kept_v", {63'b0, out_valid}, 64'd1);
    check_val("sim_kept_pc", out_pc, 64'h3000);
    for (int i = 0; i < 4; i++) step();

    // Back-to-back redirects.
    do_reset();
    lat = 3; rdy = 1; ordy = 1;
    step();
    step();
    redir = 1; redir_pc = 64'h400;
    step();
    redir_pc = 64'h800;
    step();
    redir = 0;
    for (int i = 0; i < 12; i++) step();
    check_val("b2b_first_pc", first_pc, 64'h800);

    // Address wrap-around.
    do_reset();
    lat = 1; rdy = 1; ordy = 1;
    redir = 1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redir = 0;
    check_val("wr_req_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check_val("wr_next_fetch", req_addr, 64'h0);
    step();
    check_val("wr_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_val("wr_out_pc4", out_pc4, 64'h0);
    step();
    check_val("wr_after_pc", out_pc, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_fetch_queue.md
# core_fetch_queue

Decoupled, parametrised instruction-fetch front end for the core pipeline: it generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel with up to `MAX_OUTSTANDING` requests in flight, and buffers in-order responses in a `DEPTH`-entry queue. Decode drains the queue through a valid/ready port that carries `{pc, pc+4, inst}`. A redirect (branch/exception) retargets fetch in one cycle, drops the queue, and silently discards every response still in flight. It sits between the PC-select logic and the ID stage.

## Interface
- `RESET_PC`, 64'h100, first fetch address after reset
- `ADDR_W`, 64, address/PC width
- `INST_W`, 32, instruction width
- `DEPTH`, 4, instruction-queue entries (power of two, ≥2)
- `MAX_OUTSTANDING`, 2, max in-flight requests (≥1, ≤`DEPTH`)
- `clock` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `redirect` in 1: flush and restart fetch at `redirect_pc`
- `redirect_pc` in `ADDR_W`: new fetch address, word aligned
- `req_valid` out 1: fetch request valid
- `req_addr` out `ADDR_W`: fetch address
- `req_ready` in 1: memory accepts request
- `resp_valid` in 1: instruction returned (in request order, never back-pressured)
- `resp_inst` in `INST_W`: returned instruction
- `out_valid` out 1: queue head valid
- `out_inst` out `INST_W`: head instruction
- `out_pc` out `ADDR_W`: head PC
- `out_pc4` out `ADDR_W`: head PC + 4
- `out_ready` in 1: decode consumes head (low = stall)
- `occupancy` out `$clog2(DEPTH+1)`: queue entry count

## Operation
- State: `fetch_pc` (next address to issue), `resp_pc` (PC of the next kept response), `inflight` (0..`MAX_OUTSTANDING`), `drop_cnt` (0..`MAX_OUTSTANDING`), queue with head/tail pointers and `count`.
- Issue: `req_valid = (inflight < MAX_OUTSTANDING) && (count + inflight - drop_cnt < DEPTH)`. This reserves a queue slot for every kept in-flight request, so the queue never overflows. `req_addr = fetch_pc`. A fire is `req_valid && req_ready`, which sets `fetch_pc += 4` and `inflight += 1`.
- Response: each `resp_valid` decrements `inflight`. If `drop_cnt > 0`, the response is discarded and `drop_cnt -= 1`. Otherwise `{resp_pc, resp_inst}` is written at the tail and `resp_pc += 4`.
- Output: `out_*` reflect the head entry. A pop is `out_valid && out_ready`. `out_pc4 = out_pc + 4`, computed modulo 2^`ADDR_W`; wrap-around is legal and unflagged.
- Fire, response and pop can occur in the same cycle. `count` nets +1/-1 accordingly. `inflight` nets the fire and the response.
- Redirect has priority over everything:
  - `fetch_pc <= redirect_pc`, `resp_pc <= redirect_pc`, queue cleared (`count <= 0`).
  - A response arriving in the redirect cycle is discarded and does not decrement `drop_cnt`.
  - A fire in the redirect cycle uses the old `fetch_pc` and counts as in flight.
  - `drop_cnt <= inflight + fire - resp_valid`, i.e. every request still outstanding after this cycle.
  - A pop in the redirect cycle has no effect beyond the clear.
- Requests issued after a redirect may proceed while old responses are still draining. In-order return guarantees the first `drop_cnt` responses are the stale ones.
- A redirect while `drop_cnt > 0` is legal; `drop_cnt` is recomputed by the same rule.

## Timing
- Reset values: `fetch_pc = resp_pc = RESET_PC`, `inflight = drop_cnt = count = 0`. Outputs: `out_valid = 0`, `out_inst = 0`, `out_pc = 0`, `out_pc4 = 0`, `occupancy = 0`. `req_valid = 1` with `req_addr = RESET_PC` is visible from the first cycle after reset, since it is derived from state.
- Reset asserted mid-operation returns to the reset state immediately. Any later responses to pre-reset requests are the memory's responsibility; the memory is reset together with this block.
- Latency: a response in cycle N produces `out_valid = 1` in cycle N+1. There is no combinational path from `resp_*` to `out_*`.
- `req_valid` and `req_addr` depend only on registered state, never on `req_ready`.
- Throughput: with 1-cycle memory, `MAX_OUTSTANDING ≥ 2` and `out_ready` held high, the block sustains 1 instruction/cycle.
- Redirect in cycle N: `out_valid = 0` in N+1, and `req_addr = redirect_pc` in N+1 if credit allows.

## Test plan
- Reset: release reset, memory with 1-cycle latency, `out_ready = 1` → `req_addr` sequence 0x100, 0x104, 0x108…; first `out_valid` with `out_pc = 0x100`, `out_pc4 = 0x104`; 1 instruction/cycle thereafter.
- Back-pressure: `DEPTH = 4`, `out_ready = 0` → `occupancy` reaches 4, `req_valid` stays low with `inflight = 0`, no entry lost; raising `out_ready` drains in order 0x100..0x10C.
- Redirect with in-flight requests: 3-cycle memory, `MAX_OUTSTANDING = 2`, two requests outstanding, redirect to 0x2000 → both old responses are discarded, `occupancy` goes to 0, first output `out_pc = 0x2000` with its matching instruction.
- Simultaneous redirect, fire and response: `req_ready = 1` and `resp_valid = 1` in the redirect cycle with `inflight = 1` → `drop_cnt = 1`; the next response is discarded; subsequent responses are kept starting at `redirect_pc`.
- Back-to-back redirects to 0x400 then 0x800 in consecutive cycles → no instruction from 0x400 or earlier is output; first output `out_pc = 0x800`.
- Wrap-around: redirect to 0xFFFF_FFFF_FFFF_FFFC → `out_pc4 = 0`; the next fetch is address 0.
